ether_rx_ctrl: RTL



---
 rtl/ether_rx_pkg.sv | 18 +
 rtl/erx_toggle_det.sv | 23 ++
 rtl/ether_rx_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ether_rx_pkg.sv
// Shared constants, command codes and FSM state type for the ether_rx host-side controller.
package ether_rx_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    localparam logic [3:0] CMD_GETSIZE = 4'd1;
    localparam logic [3:0] CMD_GETDATA = 4'd2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SIZE_CMD = 3'd1,
        ST_DATA_CMD = 3'd2,
        ST_OUT      = 3'd3,
        ST_GAP      = 3'd4
    } state_t;

endpackage

// File: rtl/erx_toggle_det.sv
// Turns the toggle-type erx_ready completion into a one-cycle event.
// erx_ready is launched on negedge, so no synchronizer is needed here.
module erx_toggle_det (
    input  logic erx_clk,
    input  logic erx_rst,
    input  logic i_erx_ready,
    output logic o_rdy_ev
);

    logic r_rdy_q;

    // Track the last sampled level; reset loads the live level so a standing level is not an event.
    always_ff @(posedge erx_clk) begin
        if (erx_rst) begin
            r_rdy_q <= i_erx_ready;
        end else begin
            r_rdy_q <= i_erx_ready;
        end
    end

    assign o_rdy_ev = i_erx_ready ^ r_rdy_q;

endmodule

// File: rtl/ether_rx_ctrl.sv
// Host-side sequencer for ether_rx: GETSIZE then GETDATA per word, streamed out on valid/ready.
// Optional build macro ERX_CTRL_STATS_EN adds stat_frames/stat_words/stat_timeouts counters.
module ether_rx_ctrl
    import ether_rx_pkg::*;
#(
    parameter int GAP_CYCLES     = 20,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              erx_clk,
    input  logic              erx_rst,
    output logic              erx_cs,
    output logic [3:0]        erx_cmd,
    input  logic              erx_ready,
    input  logic [DATA_W-1:0] erx_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] frame_len,
    output logic              busy,
`ifdef ERX_CTRL_STATS_EN
    output logic [15:0]       stat_frames,
    output logic [15:0]       stat_words,
    output logic [15:0]       stat_timeouts,
`endif
    output logic              err_timeout
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic              w_rdy_ev;
    state_t            r_state;
    state_t            r_next;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_frame_len;
    logic              r_cs;
    logic [3:0]        r_cmd;
    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic              r_m_last;
    logic              r_busy;
    logic              r_err_timeout;

    erx_toggle_det u_tog (
        .erx_clk     (erx_clk),
        .erx_rst     (erx_rst),
        .i_erx_ready (erx_ready),
        .o_rdy_ev    (w_rdy_ev)
    );

    // Command sequencing FSM with registered handshake and stream outputs.
    always_ff @(posedge erx_clk) begin
        if (erx_rst) begin
            r_state       <= ST_GAP;
            r_next        <= ST_IDLE;
            r_gap_cnt     <= GAP_W'(GAP_CYCLES);
            r_to_cnt      <= '0;
            r_idx         <= '0;
            r_frame_len   <= '0;
            r_cs          <= 1'b0;
            r_cmd         <= 4'd0;
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_m_last      <= 1'b0;
            r_busy        <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rdy_ev) begin
                        r_state   <= ST_GAP;
                        r_next    <= ST_SIZE_CMD;
                        r_gap_cnt <= GAP_W'(GAP_CYCLES);
                        r_busy    <= 1'b1;
                    end else begin
                        r_busy    <= 1'b0;
                    end
                end
                ST_GAP: begin
                    r_busy <= 1'b1;
                    if (r_gap_cnt == GAP_W'(0)) begin
                        r_state  <= r_next;
                        r_to_cnt <= '0;
                        case (r_next)
                            ST_SIZE_CMD: begin
                                r_cs  <= 1'b1;
                                r_cmd <= CMD_GETSIZE;
                            end
                            ST_DATA_CMD: begin
                                r_cs  <= 1'b1;
                                r_cmd <= CMD_GETDATA;
                            end
                            default: begin
                                r_busy <= 1'b0;
                            end
                        endcase
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                ST_SIZE_CMD, ST_DATA_CMD: begin
                    if (w_rdy_ev) begin
                        r_cs      <= 1'b0;
                        r_cmd     <= 4'd0;
                        r_gap_cnt <= GAP_W'(GAP_CYCLES);
                        if (r_state == ST_SIZE_CMD) begin
                            r_frame_len <= erx_data[ADDR_W-1:0];
                            r_idx       <= '0;
                            r_state     <= ST_GAP;
                            r_next      <= (erx_data[ADDR_W-1:0] == ADDR_W'(0)) ? ST_IDLE : ST_DATA_CMD;
                        end else begin
                            r_m_data  <= erx_data;
                            r_m_valid <= 1'b1;
                            r_m_last  <= (r_idx == r_frame_len - ADDR_W'(1));
                            r_state   <= ST_OUT;
                        end
                    end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        // Lost handshake: abandon the frame without ever emitting m_last.
                        r_cs          <= 1'b0;
                        r_cmd         <= 4'd0;
                        r_err_timeout <= 1'b1;
                        r_idx         <= '0;
                        r_state       <= ST_GAP;
                        r_next        <= ST_IDLE;
                        r_gap_cnt     <= GAP_W'(GAP_CYCLES);
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                ST_OUT: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        r_idx     <= r_idx + ADDR_W'(1);
                        r_state   <= ST_GAP;
                        r_next    <= r_m_last ? ST_IDLE : ST_DATA_CMD;
                        r_gap_cnt <= GAP_W'(GAP_CYCLES);
                    end else begin
                        r_m_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_GAP;
                    r_next    <= ST_IDLE;
                    r_gap_cnt <= GAP_W'(GAP_CYCLES);
                    r_cs      <= 1'b0;
                    r_cmd     <= 4'd0;
                    r_m_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ERX_CTRL_STATS_EN
    logic [15:0] r_stat_frames;
    logic [15:0] r_stat_words;
    logic [15:0] r_stat_timeouts;

    // Free-running wrap-around statistics; OUT always holds a valid word.
    always_ff @(posedge erx_clk) begin
        if (erx_rst) begin
            r_stat_frames   <= 16'd0;
            r_stat_words    <= 16'd0;
            r_stat_timeouts <= 16'd0;
        end else begin
            if (r_state == ST_OUT && m_ready) begin
                r_stat_words <= r_stat_words + 16'd1;
                if (r_m_last) begin
                    r_stat_frames <= r_stat_frames + 16'd1;
                end
            end
            if (r_err_timeout) begin
                r_stat_timeouts <= r_stat_timeouts + 16'd1;
            end
        end
    end

    assign stat_frames   = r_stat_frames;
    assign stat_words    = r_stat_words;
    assign stat_timeouts = r_stat_timeouts;
`endif

    assign erx_cs      = r_cs;
    assign erx_cmd     = r_cmd;
    assign m_valid     = r_m_valid;
    assign m_data      = r_m_data;
    assign m_last      = r_m_last;
    assign frame_len   = r_frame_len;
    assign busy        = r_busy;
    assign err_timeout = r_err_timeout;

endmodule
